nonce_tx: RTL
=============

# nonce_tx

Transmit-side framer for the miner's UART link: the counterpart of the job receive path. It drains 64-bit winning nonces from the nonce FIFO and sends each as a framed byte sequence through the UART transmitter, one byte per transmit handshake. It sits between `nonce_fifo` and `uart` in the `clk_hf` domain and replaces the separate output FSM and nonce shift register.

## Interface
Parameters:
- `SYNC_BYTE`, 8'h4E: frame header byte.
- `CHECKSUM`, 1: 1 appends an XOR checksum byte; 0 omits it.
- `BUSY_TIMEOUT`, 16: cycles to wait for `is_transmitting` after a `transmit` pulse (≥2).

Ports:
- `clk`  in  1  core clock (`clk_hf`, 100 MHz).
- `rst`  in  1  reset, asynchronous, active-low.
- `fifo_empty`  in  1  nonce FIFO empty.
- `fifo_q`  in  64  FIFO read data, valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1  FIFO read request, one-cycle pulse.
- `is_transmitting`  in  1  UART transmitter busy.
- `transmit`  out  1  UART start strobe, one-cycle pulse.
- `tx_byte`  out  8  byte to send, stable from `transmit` until the next `transmit`.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `tx_err`  out  1  sticky: UART failed to acknowledge within `BUSY_TIMEOUT`.
- `frames_sent`  out  16  completed-frame counter, wraps 16'hFFFF→0.

## Operation
- Frame: `SYNC_BYTE`, then nonce bytes LSB first (`[7:0]` … `[63:56]`), then checksum (XOR of the 8 nonce bytes) if `CHECKSUM`=1. Length is 10 bytes, or 9 without checksum.
- FSM states: IDLE, POP, LATCH, SEND, WAIT_BUSY, WAIT_IDLE.
  - IDLE: `!fifo_empty` → POP.
  - POP: `fifo_rd`=1 for this one cycle → LATCH.
  - LATCH: capture `fifo_q` into the nonce register, compute checksum, byte index←0 → SEND.
  - SEND: entered or held only while `is_transmitting`=0. Drive `tx_byte` for the current index and pulse `transmit` → WAIT_BUSY.
  - WAIT_BUSY: `is_transmitting`=1 → WAIT_IDLE. If `BUSY_TIMEOUT` cycles pass without it, set `tx_err` and treat the byte as sent (go to WAIT_IDLE).
  - WAIT_IDLE: on `is_transmitting`=0, if this was the last index then `frames_sent`++ and go to IDLE; otherwise index++ and go to SEND.
- `fifo_empty` is sampled only in IDLE. A FIFO filling or draining mid-frame has no effect.
- One nonce is read per frame. No read is issued while a frame is in progress.
- Reset, including mid-frame: state IDLE, index 0, nonce register cleared; the partial frame is abandoned and the popped nonce is lost.
- Reset values: `fifo_rd`=0, `transmit`=0, `tx_byte`=8'h00, `busy`=0, `tx_err`=0, `frames_sent`=0.

## Timing
- All outputs are registered.
- IDLE sees `fifo_empty`=0 at cycle N. `fifo_rd` is high at N+1, capture happens at N+2, `transmit` with `tx_byte`=`SYNC_BYTE` at N+3 (provided `is_transmitting`=0).
- Byte-to-byte spacing is UART frame time plus about 2 cycles. `transmit` is never asserted while `is_transmitting`=1.
- Back-to-back frames: IDLE holds for 1 cycle after the last WAIT_IDLE, then POP.
- `frames_sent` increments on the cycle WAIT_IDLE exits after the last byte.

## Structure
- `miner_pkg`: FSM state encoding, `FRAME_LEN` (10/9), default `SYNC_BYTE`, and a byte-select function (nonce, index → byte).
- Single module, no sub-module. The timeout counter and byte index are local counters sized by `$clog2`.

## Test plan
- Push 64'h0123456789ABCDEF with a UART model (busy 1 cycle after `transmit`, for 20 cycles). Required bytes: 4E EF CD AB 89 67 45 23 01 00. `frames_sent`=1, `fifo_rd` pulsed exactly once.
- Push 64'h00000000000000FF with `CHECKSUM`=0. Required: 9 bytes 4E FF 00 00 00 00 00 00 00, no checksum byte.
- Push 3 nonces back-to-back. Required: 30 bytes in order, `fifo_rd` never asserted while `busy`=1, `frames_sent`=3.
- UART model never raises `is_transmitting`. Required: `tx_err`=1 after 16 cycles per byte, frame still completes, `tx_err` stays set until reset.
- Assert `rst` low after byte 4 of a frame. Required: all outputs at their reset values immediately. After release with FIFO empty, no `transmit`.
- Hold `is_transmitting`=1 externally when a nonce arrives. Required: no `transmit` until it falls, then header on the next SEND.

Source files
------------

// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and helpers for the miner nonce transmit path
package miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h4E;
  localparam int FRAME_LEN_CSUM  = 10;
  localparam int FRAME_LEN_PLAIN = 9;

  function automatic int frame_len(input bit csum);
    return csum ? FRAME_LEN_CSUM : FRAME_LEN_PLAIN;
  endfunction

  // Nonce bytes go out least-significant first.
  function automatic logic [7:0] nonce_byte(input logic [63:0] nonce, input logic [2:0] idx);
    return nonce[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] nonce_xor(input logic [63:0] nonce);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ nonce[i*8 +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/nonce_tx.sv
// rtl/nonce_tx.sv - drains winning nonces from the FIFO and frames them onto the UART
module nonce_tx
  import miner_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter bit         CHECKSUM     = 1'b1,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [63:0] fifo_q,
  output logic        fifo_rd,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        tx_err,
  output logic [15:0] frames_sent
);

  localparam int FRAME_LEN = frame_len(CHECKSUM);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int TMR_W     = $clog2(BUSY_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  tx_state_e        state_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q;
  logic [63:0]      nonce_q;
  logic [7:0]       csum_q;
  logic             fifo_rd_q, transmit_q, busy_q, tx_err_q;
  logic [7:0]       tx_byte_q, byte_cur, byte_d;
  logic [15:0]      frames_q;

  // Index 0 is the header, 1..8 the nonce, 9 the checksum when enabled.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [63:0] nonce,
                                            input logic [7:0] csum);
    if (idx == '0) return SYNC_BYTE;
    if (idx > IDX_W'(8)) return csum;
    return nonce_byte(nonce, 3'(idx - 1'b1));
  endfunction

  always_comb begin
    idx_d    = idx_q + 1'b1;
    byte_cur = frame_byte(idx_q, nonce_q, csum_q);
    byte_d   = frame_byte(idx_d, nonce_q, csum_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      nonce_q    <= '0;
      csum_q     <= '0;
      fifo_rd_q  <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      tx_err_q   <= 1'b0;
      frames_q   <= '0;
    end else begin
      fifo_rd_q  <= 1'b0;
      transmit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_POP;
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_POP: state_q <= ST_LATCH;
        ST_LATCH: begin
          nonce_q <= fifo_q;
          csum_q  <= nonce_xor(fifo_q);
          idx_q   <= '0;
          state_q <= ST_SEND;
          // Header strobe goes out with the capture so SEND holds the pulse cycle.
          if (!is_transmitting) begin
            transmit_q <= 1'b1;
            tx_byte_q  <= SYNC_BYTE;
          end
        end
        ST_SEND: begin
          if (transmit_q) begin
            state_q <= ST_WAIT_BUSY;
            tmr_q   <= '0;
          end else if (!is_transmitting) begin
            transmit_q <= 1'b1;
            tx_byte_q  <= byte_cur;
          end
        end
        ST_WAIT_BUSY: begin
          if (is_transmitting) begin
            state_q <= ST_WAIT_IDLE;
          end else if (tmr_q == TMR_LAST) begin
            tx_err_q <= 1'b1;
            state_q  <= ST_WAIT_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!is_transmitting) begin
            if (idx_q == LAST_IDX) begin
              frames_q <= frames_q + 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              idx_q      <= idx_d;
              transmit_q <= 1'b1;
              tx_byte_q  <= byte_d;
              state_q    <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign transmit    = transmit_q;
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign tx_err      = tx_err_q;
  assign frames_sent = frames_q;

endmodule
